trig_ctrl_param: RTL

Parametrised successor to the fixed five-channel AND trigger latch in the capture path. Combines NUM_CH channel trigger qualifiers and a protocol trigger under a per-source enable mask, with selectable AND/OR combining. Runs an arm -> qualify -> trigger -> post-trigger-count -> done state machine. Reports trigger status and the source snapshot to the capture/RAM controller, and ends capture itself after a programmable post-trigger sample count.

---
 rtl/trig_ctrl_param_if.sv | 36 +++
 rtl/trig_ctrl_param.sv | 101 ++++++++++
 2 files changed

// File: rtl/trig_ctrl_param_if.sv
// Trigger controller bus: trigger sources, configuration and status.
// master drives sources/config and reads status; slave is the controller.
interface trig_ctrl_param_if #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 9
);
    logic [NUM_CH-1:0] ch_trig;
    logic [NUM_CH-1:0] ch_mask;
    logic              prot_trig;
    logic              prot_en;
    logic              mode_or;
    logic              arm;
    logic              abort;
    logic [CNT_W-1:0]  post_cnt;
    logic              smpl_en;
    logic              armed;
    logic              triggered;
    logic              trig_pulse;
    logic              capture_done;
    logic [NUM_CH:0]   trig_src;
    logic [CNT_W-1:0]  post_left;

    modport master (
        output ch_trig, ch_mask, prot_trig, prot_en, mode_or,
        output arm, abort, post_cnt, smpl_en,
        input  armed, triggered, trig_pulse, capture_done,
        input  trig_src, post_left
    );

    modport slave (
        input  ch_trig, ch_mask, prot_trig, prot_en, mode_or,
        input  arm, abort, post_cnt, smpl_en,
        output armed, triggered, trig_pulse, capture_done,
        output trig_src, post_left
    );
endinterface

// File: rtl/trig_ctrl_param.sv
// Parametrised trigger controller: masked AND/OR source combining,
// arm/qualify/trigger/post-count/done FSM. Ports: clk, rst_n, bus (slave).
module trig_ctrl_param #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 9
) (
    input logic              clk,
    input logic              rst_n,
    trig_ctrl_param_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ARM_WAIT,
        ARMED,
        POST,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              pulse_q, pulse_d;
    logic [NUM_CH:0]   src_q, src_d;
    logic [CNT_W-1:0]  left_q, left_d;

    logic any_en;
    logic and_v;
    logic or_v;
    logic trig_set;

    assign any_en = (|bus.ch_mask) | bus.prot_en;
    assign and_v  = (&(bus.ch_trig | ~bus.ch_mask))
                  & (bus.prot_trig | ~bus.prot_en);
    assign or_v   = (|(bus.ch_trig & bus.ch_mask))
                  | (bus.prot_trig & bus.prot_en);
    // With nothing enabled the AND form would be vacuously true.
    assign trig_set = any_en & (bus.mode_or ? or_v : and_v);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            src_q   <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            src_q   <= src_d;
            left_q  <= left_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        src_d   = src_q;
        left_d  = left_q;
        if (bus.abort) begin
            // Snapshot and remaining count stay visible after an abort.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.arm) state_d = ARM_WAIT;
                end
                ARM_WAIT: begin
                    // Reject a level already active when armed.
                    if (!trig_set) state_d = ARMED;
                end
                ARMED: begin
                    if (trig_set) begin
                        pulse_d = 1'b1;
                        src_d   = {bus.prot_trig & bus.prot_en,
                                   bus.ch_trig & bus.ch_mask};
                        left_d  = bus.post_cnt;
                        state_d = (bus.post_cnt == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (bus.smpl_en) begin
                        if (left_q > CNT_W'(1)) begin
                            left_d = left_q - CNT_W'(1);
                        end else begin
                            left_d  = '0;
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.arm) state_d = ARM_WAIT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.armed        = (state_q == ARM_WAIT) || (state_q == ARMED);
    assign bus.triggered    = (state_q == POST) || (state_q == DONE);
    assign bus.capture_done = (state_q == DONE);
    assign bus.trig_pulse   = pulse_q;
    assign bus.trig_src     = src_q;
    assign bus.post_left    = left_q;
endmodule
